// File: rtl/sdram_init_chk_pkg.sv
// Shared encodings for the SDRAM init checker: command codes, error codes,
// checker states and the elapsed-cycle counter helper.
package sdram_init_chk_pkg;

  // {cs_n, ras_n, cas_n, we_n} with cs_n low
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_EARLY    = 3'd1;
  localparam logic [2:0] ERR_ORDER    = 3'd2;
  localparam logic [2:0] ERR_PRE_ALL  = 3'd3;
  localparam logic [2:0] ERR_MRS_BANK = 3'd4;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_TRP   = 3'd1,
    S_TRFC  = 3'd2,
    S_TMRD  = 3'd3,
    S_READY = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sdram_init_chk_cmd_decode.sv
// Combinational SDRAM command classifier; DESEL and NOP both count as idle.
module sdram_cmd_decode
  import sdram_init_chk_pkg::*;
(
  input  logic [3:0] cmd_i,
  output logic       is_idle_o,
  output logic       is_pre_o,
  output logic       is_ar_o,
  output logic       is_mrs_o
);

  always_comb begin
    is_idle_o = cmd_i[3] || (cmd_i == CMD_NOP);
    is_pre_o  = (cmd_i == CMD_PRE);
    is_ar_o   = (cmd_i == CMD_AR);
    is_mrs_o  = (cmd_i == CMD_MRS);
  end

endmodule

// File: rtl/sdram_init_chk.sv
// Device-side checker for the SDRAM power-up sequence: enforces order and
// minimum spacing of PRE-all / AUTO REFRESH / MRS and latches the mode register.
module sdram_init_chk
  import sdram_init_chk_pkg::*;
#(
  parameter int T_POWER = 20000,
  parameter int T_RP    = 2,
  parameter int T_RFC   = 7,
  parameter int T_MRD   = 3,
  parameter int AR_NUM  = 8
) (
  input  logic        chk_clk,
  input  logic        chk_rst_n,
  input  logic [3:0]  chk_cmd,
  input  logic [1:0]  chk_bank,
  input  logic [12:0] chk_addr,
  output logic        chk_ready,
  output logic        chk_err,
  output logic [2:0]  chk_err_code,
  output logic [12:0] chk_mode_reg,
  output logic [2:0]  chk_cas_lat,
  output logic [2:0]  chk_burst_len,
  output logic [3:0]  chk_ar_cnt
);

  localparam logic [CNT_W-1:0] T_POWER_C = CNT_W'(T_POWER);
  localparam logic [CNT_W-1:0] T_RP_C    = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] T_RFC_C   = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] T_MRD_C   = CNT_W'(T_MRD);
  localparam logic [3:0]       AR_NUM_C  = 4'(AR_NUM);

  logic is_idle, is_pre, is_ar, is_mrs;

  sdram_cmd_decode u_dec (
    .cmd_i     (chk_cmd),
    .is_idle_o (is_idle),
    .is_pre_o  (is_pre),
    .is_ar_o   (is_ar),
    .is_mrs_o  (is_mrs)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ar_q, ar_d;
  logic [12:0]      mode_q, mode_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             viol;
  logic [2:0]       viol_code;

  // State register and registered outputs
  always_ff @(posedge chk_clk or negedge chk_rst_n) begin
    if (!chk_rst_n) begin
      state_q <= S_PWR;
      cnt_q   <= '0;
      ar_q    <= '0;
      mode_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ar_q    <= ar_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic; each state lists its checks in priority order
  always_comb begin
    state_d   = state_q;
    cnt_d     = is_idle ? sat_inc(cnt_q) : CNT_W'(1);
    ar_d      = ar_q;
    mode_d    = mode_q;
    ready_d   = ready_q;
    err_d     = err_q;
    code_d    = code_q;
    viol      = 1'b0;
    viol_code = ERR_NONE;

    case (state_q)
      S_PWR: begin
        if (!is_idle) begin
          if (is_pre) begin
            if (cnt_q < T_POWER_C) begin
              viol      = 1'b1;
              viol_code = ERR_EARLY;
            end else if (!chk_addr[10]) begin
              viol      = 1'b1;
              viol_code = ERR_PRE_ALL;
            end else begin
              state_d = S_TRP;
            end
          end else begin
            viol      = 1'b1;
            viol_code = ERR_ORDER;
          end
        end
      end

      S_TRP: begin
        if (!is_idle) begin
          if (cnt_q < T_RP_C) begin
            viol      = 1'b1;
            viol_code = ERR_EARLY;
          end else if (is_ar) begin
            state_d = S_TRFC;
            ar_d    = 4'd1;
          end else begin
            viol      = 1'b1;
            viol_code = ERR_ORDER;
          end
        end
      end

      S_TRFC: begin
        if (!is_idle) begin
          if (cnt_q < T_RFC_C) begin
            viol      = 1'b1;
            viol_code = ERR_EARLY;
          end else if (is_mrs && (chk_bank != 2'b00)) begin
            viol      = 1'b1;
            viol_code = ERR_MRS_BANK;
          end else if (is_ar && (ar_q < AR_NUM_C)) begin
            ar_d = ar_q + 4'd1;
          end else if (is_mrs && (ar_q == AR_NUM_C)) begin
            mode_d  = chk_addr;
            state_d = S_TMRD;
          end else begin
            viol      = 1'b1;
            viol_code = ERR_ORDER;
          end
        end
      end

      S_TMRD: begin
        if (!is_idle && (cnt_q < T_MRD_C)) begin
          viol      = 1'b1;
          viol_code = ERR_EARLY;
        end else if (cnt_q >= T_MRD_C) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end

      // READY is terminal and ERR keeps its first code
      S_READY, S_ERR: begin
      end

      default: begin
        state_d = S_ERR;
      end
    endcase

    if (viol) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      code_d  = viol_code;
    end
  end

  // Output decode from registered state
  always_comb begin
    chk_ready     = ready_q;
    chk_err       = err_q;
    chk_err_code  = code_q;
    chk_mode_reg  = mode_q;
    chk_cas_lat   = mode_q[6:4];
    chk_burst_len = mode_q[2:0];
    chk_ar_cnt    = ar_q;
  end

endmodule
